instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Multicycle front end of the RISC-V core; sits directly upstream of the Control decoder.
//  Owns the PC and fetches from instruction memory over a req/ack handshake.
//  Holds the fetched word and presents opcode/funct3/funct7 to Control.
//  Consumes Control's Branch/PcUpdate/Pc_Target_Src plus datapath imm/ALU result to select the next PC.
// PARAMETERS
//  RESET_PC  32'h0040_0000  PC loaded on reset (text segment base)
//  NOP_INSTR 32'h0000_0013  instruction register value at reset (addi x0,x0,0)
// PORTS
//  clk            in   1   system clock, rising edge
//  reset          in   1   asynchronous, active-high reset
//  imem_req       out  1   fetch request to instruction memory
//  imem_addr      out  32  fetch address (= pc)
//  imem_rdata     in   32  instruction word, valid when imem_ack=1
//  imem_ack       in   1   memory completes fetch this cycle (may coincide with req)
//  stall_i        in   1   datapath holds current instruction in EXEC
//  branch_i       in   1   conditional branch taken (Control Branch)
//  pc_update_i    in   1   unconditional jump (Control PcUpdate)
//  pc_target_src_i in  1   0: target=pc+imm_i; 1: target=alu_result_i & ~1 (JALR)
//  imm_i          in   32  sign-extended immediate from immediate generator
//  alu_result_i   in   32  ALU result (rs1+imm for JALR)
//  instr_valid    out  1   instruction register valid; datapath executes this cycle
//  instr          out  32  held instruction word
//  opcode         out  7   instr[6:0]
//  funct3         out  3   instr[14:12]
//  funct7         out  7   instr[31:25]
//  pc             out  32  address of held instruction
//  pc_plus4       out  32  pc+4 (JAL/JALR link value)
//  misalign_o     out  1   sticky: misaligned next-PC detected; core trapped
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, pc=RESET_PC, instr=NOP_INSTR, imem_req=0,
//   instr_valid=0, misalign_o=0. Asserting reset mid-fetch abandons the fetch; req drops same cycle.
//  States: IDLE -> FETCH -> (WAIT) -> EXEC -> FETCH ... ; TRAP terminal.
//  IDLE: one cycle after reset release, req=0; -> FETCH.
//  FETCH: imem_req=1, imem_addr=pc. ack=1 -> latch instr<=imem_rdata, -> EXEC; else -> WAIT.
//  WAIT: req and addr held stable; on ack latch instr, -> EXEC.
//  imem_ack outside FETCH/WAIT is ignored; imem_rdata sampled only when ack=1.
//  EXEC: instr_valid=1, req=0. stall_i=1 -> stay, pc/instr unchanged.
//   stall_i=0: taken = branch_i | pc_update_i;
//   target = pc_target_src_i ? (alu_result_i & 32'hFFFF_FFFE) : pc+imm_i;
//   next = taken ? target : pc+4; all adds are 32-bit modulo 2^32 (0xFFFF_FFFC+4 -> 0).
//   next[1:0]!=0 -> misalign_o<=1, pc held, -> TRAP; else pc<=next, -> FETCH.
//  TRAP: req=0, instr_valid=0; only reset exits.
//  Latency: zero-wait memory = 2 cycles/instruction; each ack wait state adds 1.
//  opcode/funct3/funct7/pc/pc_plus4 are combinational from registers; stable for all of EXEC.
// STRUCTURE
//  Shared package riscv_pkg: opcode constants (0x33,0x13,0x03,0x67,0x23,0x6f,0x63,0x17),
//   NOP_INSTR, RESET_PC default, fetch-state encoding.
//  Sub-module pc_next_logic: combinational next-PC mux, JALR LSB clear, misalignment check.
//  Top holds FSM, PC and instruction registers.
// TESTING
//  1 Reset in WAIT -> req=0 same cycle, pc=0x0040_0000; after release: 1 IDLE cycle, then req addr 0x0040_0000.
//  2 Zero-wait ack, rdata 0x0050_0093 -> opcode 0x13, funct3 0, instr_valid 1 cycle; next addr 0x0040_0004.
//  3 ack delayed 3 cycles -> req/addr stable 4 cycles, instr_valid rises cycle after ack.
//  4 pc 0x0040_0010, branch_i=1, imm -16 -> next addr 0x0040_0000; branch_i=0 -> 0x0040_0014.
//  5 pc_update_i=1, pc_target_src_i=1, alu_result 0x0040_0101 -> next addr 0x0040_0100; stall_i 2 cycles holds EXEC.
//  6 Branch target 0x0040_0012 -> misalign_o=1, TRAP, req stays 0, pc=0x0040_0010 until reset.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: opcode constants, reset defaults and the
// fetch-unit state encoding.
package riscv_pkg;

    localparam logic [6:0] OPC_R_TYPE = 7'h33;
    localparam logic [6:0] OPC_I_ALU  = 7'h13;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_JAL    = 7'h6f;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_EXEC  = 3'd3,
        S_TRAP  = 3'd4
    } fetch_state_t;

    // Instructions are 32-bit only (no compressed extension), so any
    // address not on a word boundary is a fault.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/pc_next_logic.sv
// Combinational next-PC selection: sequential, PC-relative or register-based
// (JALR) target, plus misalignment detection on the chosen address.
module pc_next_logic
    import riscv_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        branch,
    input  logic        pc_update,
    input  logic        pc_target_src,
    input  logic [31:0] imm,
    input  logic [31:0] alu_result,
    output logic [31:0] pc_plus4,
    output logic [31:0] next_pc,
    output logic        misalign
);

    logic [31:0] target;
    logic        taken;

    assign pc_plus4 = pc + 32'd4;
    assign taken    = branch | pc_update;

    // JALR clears bit 0 of the computed address; bit 1 is still checked below.
    assign target   = pc_target_src ? (alu_result & 32'hFFFF_FFFE) : (pc + imm);
    assign next_pc  = taken ? target : pc_plus4;
    assign misalign = is_misaligned(next_pc);

endmodule

// File: rtl/instr_fetch_unit.sv
// Multicycle instruction fetch front end: owns the PC, runs the imem req/ack
// handshake and holds the current instruction for the Control decoder.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = riscv_pkg::RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    input  logic        stall_i,
    input  logic        branch_i,
    input  logic        pc_update_i,
    input  logic        pc_target_src_i,
    input  logic [31:0] imm_i,
    input  logic [31:0] alu_result_i,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        misalign_o
);
    import riscv_pkg::*;

    fetch_state_t state;
    logic [31:0]  next_pc;
    logic         next_misalign;

    pc_next_logic u_pc_next (
        .pc            (pc),
        .branch        (branch_i),
        .pc_update     (pc_update_i),
        .pc_target_src (pc_target_src_i),
        .imm           (imm_i),
        .alu_result    (alu_result_i),
        .pc_plus4      (pc_plus4),
        .next_pc       (next_pc),
        .misalign      (next_misalign)
    );

    assign imem_addr = pc;
    assign opcode    = instr[6:0];
    assign funct3    = instr[14:12];
    assign funct7    = instr[31:25];

    // imem_req and instr_valid are registered alongside the state so they
    // reflect the state being entered, never a combinational decode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            instr       <= NOP_INSTR;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            misalign_o  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    state    <= S_FETCH;
                    imem_req <= 1'b1;
                end
                S_FETCH, S_WAIT: begin
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        state       <= S_EXEC;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_EXEC: begin
                    if (!stall_i) begin
                        instr_valid <= 1'b0;
                        if (next_misalign) begin
                            // PC stays on the faulting instruction for the trap handler.
                            misalign_o <= 1'b1;
                            state      <= S_TRAP;
                        end else begin
                            pc       <= next_pc;
                            state    <= S_FETCH;
                            imem_req <= 1'b1;
                        end
                    end
                end
                S_TRAP: begin
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
                default: begin
                    state       <= S_IDLE;
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: expected fetch addresses and
// instruction words are queued as stimulus is issued and checked on output.
module tb_instr_fetch_unit;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic        stall_i;
    logic        branch_i;
    logic        pc_update_i;
    logic        pc_target_src_i;
    logic [31:0] imm_i;
    logic [31:0] alu_result_i;
    logic        instr_valid;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misalign_o;

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_instr_q[$];
    logic [31:0] mpc;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .imem_ack        (imem_ack),
        .stall_i         (stall_i),
        .branch_i        (branch_i),
        .pc_update_i     (pc_update_i),
        .pc_target_src_i (pc_target_src_i),
        .imm_i           (imm_i),
        .alu_result_i    (alu_result_i),
        .instr_valid     (instr_valid),
        .instr           (instr),
        .opcode          (opcode),
        .funct3          (funct3),
        .funct7          (funct7),
        .pc              (pc),
        .pc_plus4        (pc_plus4),
        .misalign_o      (misalign_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; waits for the request, serves it after dly wait states.
    task automatic fetch(input int dly, input logic [31:0] word);
        logic [31:0] ea;
        int n;
        n = 0;
        while (!imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!imem_req) begin
            chk("req_timeout", 32'd0, 32'd1);
            return;
        end
        if (exp_addr_q.size() == 0) begin
            chk("addr_sb_empty", 32'd0, 32'd1);
            return;
        end
        ea = exp_addr_q.pop_front();
        exp_instr_q.push_back(word);
        for (int d = 0; d <= dly; d++) begin
            chk("fetch_req", {31'd0, imem_req}, 32'd1);
            chk("fetch_addr", imem_addr, ea);
            imem_ack   = (d == dly);
            imem_rdata = (d == dly) ? word : 32'hDEAD_BEEF;
            @(negedge clk);
        end
        imem_ack   = 1'b0;
        imem_rdata = 32'h0BAD_0BAD;
        chk("exec_valid", {31'd0, instr_valid}, 32'd1);
        chk("exec_req_low", {31'd0, imem_req}, 32'd0);
        chk("exec_instr", instr, exp_instr_q.pop_front());
    endtask

    // Called at the first EXEC negedge; exp_next is the spec-derived next PC.
    task automatic exec(input int stalls, input logic br, input logic pu, input logic src,
                        input logic [31:0] imm, input logic [31:0] alu, input logic [31:0] exp_next);
        for (int s = 0; s < stalls; s++) begin
            stall_i = 1'b1; branch_i = br; pc_update_i = pu;
            pc_target_src_i = src; imm_i = imm; alu_result_i = alu;
            @(negedge clk);
            chk("stall_valid", {31'd0, instr_valid}, 32'd1);
            chk("stall_pc", pc, mpc);
        end
        stall_i = 1'b0; branch_i = br; pc_update_i = pu;
        pc_target_src_i = src; imm_i = imm; alu_result_i = alu;
        @(negedge clk);
        branch_i = 1'b0; pc_update_i = 1'b0; pc_target_src_i = 1'b0;
        imm_i = 32'd0; alu_result_i = 32'd0;
        chk("valid_drop", {31'd0, instr_valid}, 32'd0);
        if (exp_next[1:0] != 2'b00) begin
            chk("misalign_set", {31'd0, misalign_o}, 32'd1);
            chk("trap_pc", pc, mpc);
        end else begin
            chk("misalign_clr", {31'd0, misalign_o}, 32'd0);
            mpc = exp_next;
            exp_addr_q.push_back(exp_next);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; imem_ack = 1'b0; imem_rdata = 32'd0; stall_i = 1'b0;
        branch_i = 1'b0; pc_update_i = 1'b0; pc_target_src_i = 1'b0;
        imm_i = 32'd0; alu_result_i = 32'd0; mpc = 32'h0040_0000;
        @(negedge clk); @(negedge clk);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_pc", pc, 32'h0040_0000);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_misalign", {31'd0, misalign_o}, 32'd0);

        // Reset asserted while waiting on memory abandons the fetch.
        reset = 1'b0; #1;
        chk("idle_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        chk("wait_req", {31'd0, imem_req}, 32'd1);
        @(negedge clk); @(negedge clk);
        chk("wait_req_hold", {31'd0, imem_req}, 32'd1);
        chk("wait_addr_hold", imem_addr, 32'h0040_0000);
        reset = 1'b1; #1;
        chk("midrst_req", {31'd0, imem_req}, 32'd0);
        chk("midrst_pc", pc, 32'h0040_0000);
        @(negedge clk);
        reset = 1'b0; #1;
        chk("idle2_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);

        // Zero-wait fetch of addi x1,x0,5.
        exp_addr_q.push_back(32'h0040_0000);
        fetch(0, 32'h0050_0093);
        chk("opcode", {25'd0, opcode}, {25'd0, OPC_I_ALU});
        chk("funct3", {29'd0, funct3}, 32'd0);
        chk("funct7", {25'd0, funct7}, 32'd0);
        chk("pc_plus4", pc_plus4, 32'h0040_0004);
        exec(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'h0040_0004);

        // Three wait states; an R-type word exercises funct3/funct7.
        fetch(3, 32'h4020_D0B3);
        chk("opcode_r", {25'd0, opcode}, {25'd0, OPC_R_TYPE});
        chk("funct3_r", {29'd0, funct3}, 32'd5);
        chk("funct7_r", {25'd0, funct7}, 32'h20);
        exec(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'h0040_0008);
        fetch(1, 32'h0000_0013);
        exec(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'h0040_000C);
        fetch(0, 32'h0000_0013);
        exec(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'h0040_0010);

        // Taken branch backwards, forwards, then not taken.
        fetch(0, 32'hFE00_08E3);
        chk("pc_0x10", pc, 32'h0040_0010);
        exec(0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'd0, 32'h0040_0000);
        fetch(0, 32'h0000_0863);
        exec(0, 1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'd0, 32'h0040_0010);
        fetch(2, 32'h0000_0863);
        exec(0, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'd0, 32'h0040_0014);

        // JALR with odd ALU result and two stall cycles, then JAL back.
        fetch(0, 32'h1000_00E7);
        chk("opcode_jalr", {25'd0, opcode}, {25'd0, OPC_JALR});
        exec(2, 1'b0, 1'b1, 1'b1, 32'd0, 32'h0040_0101, 32'h0040_0100);
        fetch(0, 32'hF11F_F0EF);
        exec(0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FF10, 32'd0, 32'h0040_0010);

        // Misaligned branch target traps and stays trapped.
        fetch(0, 32'h0000_0163);
        exec(0, 1'b1, 1'b0, 1'b0, 32'h0000_0002, 32'd0, 32'h0040_0012);
        for (int i = 0; i < 4; i++) begin
            imem_ack = i[0];
            imem_rdata = 32'h1234_5678;
            @(negedge clk);
            chk("trap_req", {31'd0, imem_req}, 32'd0);
            chk("trap_valid", {31'd0, instr_valid}, 32'd0);
            chk("trap_pc_hold", pc, 32'h0040_0010);
            chk("trap_sticky", {31'd0, misalign_o}, 32'd1);
        end
        imem_ack = 1'b0;

        // Reset clears the trap; check PC wrap at the top of the address space.
        reset = 1'b1; #1;
        chk("trap_rst_misalign", {31'd0, misalign_o}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        mpc = 32'h0040_0000;
        exp_addr_q.delete();
        exp_addr_q.push_back(32'h0040_0000);
        @(negedge clk);
        fetch(0, 32'h0000_0067);
        exec(0, 1'b0, 1'b1, 1'b1, 32'd0, 32'hFFFF_FFFD, 32'hFFFF_FFFC);
        fetch(0, 32'h0000_0013);
        chk("pc_plus4_wrap", pc_plus4, 32'h0000_0000);
        exec(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'h0000_0000);
        fetch(0, 32'h0000_0013);
        chk("wrap_pc", pc, 32'h0000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
